// File: rtl/rgb_csk_pkg.sv
// Shared constants for the RGB colour-shift-keying link: channel levels,
// slicer thresholds, demodulator state encoding and index field layout.
package rgb_csk_pkg;

    localparam logic [7:0] LVL0 = 8'd0;
    localparam logic [7:0] LVL1 = 8'd85;
    localparam logic [7:0] LVL2 = 8'd160;
    localparam logic [7:0] LVL3 = 8'd255;

    // Midpoints between adjacent levels, rounded up
    localparam logic [7:0] T01_DEF = 8'd43;
    localparam logic [7:0] T12_DEF = 8'd123;
    localparam logic [7:0] T23_DEF = 8'd208;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_e;

    localparam int IDX_W = 6;
    localparam int R_LSB = 0;
    localparam int G_LSB = 2;
    localparam int B_LSB = 4;

    function automatic logic [IDX_W-1:0] pack_index(input logic [1:0] r,
                                                    input logic [1:0] g,
                                                    input logic [1:0] b);
        logic [IDX_W-1:0] idx;
        idx              = '0;
        idx[R_LSB +: 2]  = r;
        idx[G_LSB +: 2]  = g;
        idx[B_LSB +: 2]  = b;
        return idx;
    endfunction

endpackage

// File: rtl/level_slicer.sv
// Maps one averaged 8-bit channel amplitude to the nearest 2-bit CSK level.
module level_slicer #(
    parameter logic [7:0] T01 = 8'd43,
    parameter logic [7:0] T12 = 8'd123,
    parameter logic [7:0] T23 = 8'd208
) (
    input  logic [7:0] avg_i,
    output logic [1:0] level_o
);

    always_comb begin
        level_o = 2'd0;
        if (avg_i >= T23) begin
            level_o = 2'd3;
        end else if (avg_i >= T12) begin
            level_o = 2'd2;
        end else if (avg_i >= T01) begin
            level_o = 2'd1;
        end
    end

endmodule

// File: rtl/rgb_to_index.sv
// CSK demodulator: integrates SPS RGB samples per symbol, slices the averages
// to 2-bit levels and hands the 6-bit index downstream over valid/ready.
module rgb_to_index
    import rgb_csk_pkg::*;
#(
    parameter int         LOG2_SPS = 2,
    parameter logic [7:0] T01      = T01_DEF,
    parameter logic [7:0] T12      = T12_DEF,
    parameter logic [7:0] T23      = T23_DEF
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       enable,
    input  logic       sample_valid,
    input  logic       sym_start,
    input  logic [7:0] R_in,
    input  logic [7:0] G_in,
    input  logic [7:0] B_in,
    output logic [5:0] index_out,
    output logic       index_valid,
    input  logic       index_ready,
    output logic       overflow,
    input  logic       clear_ovf,
    output logic       state_out
);

    localparam int               ACC_W = 8 + LOG2_SPS;
    localparam int               CNT_W = LOG2_SPS + 1;
    localparam logic [CNT_W-1:0] SPS   = CNT_W'(1 << LOG2_SPS);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] acc_r_q, acc_g_q, acc_b_q;
    logic [ACC_W-1:0] acc_r_d, acc_g_d, acc_b_d;
    logic             dec_valid_q;
    logic [7:0]       dec_r_q, dec_g_q, dec_b_q;
    logic [5:0]       index_q;
    logic             index_valid_q;
    logic             overflow_q;

    logic             take;
    logic             sym_done;
    logic             load;
    logic             out_free;
    logic [1:0]       lvl_r, lvl_g, lvl_b;
    logic [5:0]       idx_new;

    // In IDLE only a sym_start sample is accepted; sym_start in ACCUM is a resync
    always_comb begin
        take     = enable & sample_valid & ((state_q == ACCUM) | sym_start);
        acc_r_d  = (sym_start ? '0 : acc_r_q) + ACC_W'(R_in);
        acc_g_d  = (sym_start ? '0 : acc_g_q) + ACC_W'(G_in);
        acc_b_d  = (sym_start ? '0 : acc_b_q) + ACC_W'(B_in);
        cnt_d    = sym_start ? CNT_W'(1) : cnt_q + CNT_W'(1);
        sym_done = take & (cnt_d == SPS);
        load     = dec_valid_q & enable;
        out_free = ~index_valid_q | index_ready;
    end

    level_slicer #(.T01(T01), .T12(T12), .T23(T23)) u_slice_r (
        .avg_i   (dec_r_q),
        .level_o (lvl_r)
    );

    level_slicer #(.T01(T01), .T12(T12), .T23(T23)) u_slice_g (
        .avg_i   (dec_g_q),
        .level_o (lvl_g)
    );

    level_slicer #(.T01(T01), .T12(T12), .T23(T23)) u_slice_b (
        .avg_i   (dec_b_q),
        .level_o (lvl_b)
    );

    assign idx_new = pack_index(lvl_r, lvl_g, lvl_b);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            acc_r_q       <= '0;
            acc_g_q       <= '0;
            acc_b_q       <= '0;
            dec_valid_q   <= 1'b0;
            dec_r_q       <= '0;
            dec_g_q       <= '0;
            dec_b_q       <= '0;
            index_q       <= '0;
            index_valid_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            if (!enable) begin
                state_q     <= IDLE;
                cnt_q       <= '0;
                acc_r_q     <= '0;
                acc_g_q     <= '0;
                acc_b_q     <= '0;
                dec_valid_q <= 1'b0;
            end else begin
                dec_valid_q <= sym_done;
                if (take) begin
                    state_q <= ACCUM;
                    if (sym_done) begin
                        // Truncating average; symbol timing then free-runs
                        dec_r_q <= acc_r_d[LOG2_SPS +: 8];
                        dec_g_q <= acc_g_d[LOG2_SPS +: 8];
                        dec_b_q <= acc_b_d[LOG2_SPS +: 8];
                        acc_r_q <= '0;
                        acc_g_q <= '0;
                        acc_b_q <= '0;
                        cnt_q   <= '0;
                    end else begin
                        acc_r_q <= acc_r_d;
                        acc_g_q <= acc_g_d;
                        acc_b_q <= acc_b_d;
                        cnt_q   <= cnt_d;
                    end
                end
            end

            if (load && out_free) begin
                index_q       <= idx_new;
                index_valid_q <= 1'b1;
            end else if (index_valid_q && index_ready) begin
                index_valid_q <= 1'b0;
            end

            // A drop on the same edge as clear_ovf keeps the flag set
            if (load && !out_free) begin
                overflow_q <= 1'b1;
            end else if (clear_ovf) begin
                overflow_q <= 1'b0;
            end
        end
    end

    assign index_out   = index_q;
    assign index_valid = index_valid_q;
    assign overflow    = overflow_q;
    assign state_out   = (state_q == ACCUM);

endmodule

// File: tb/tb_rgb_to_index.sv
// Self-checking bench for rgb_to_index: vector table plus scoreboard queues,
// with an SPS=1 instance for the threshold sweep.
module tb_rgb_to_index;

    logic       clk = 1'b0;
    logic       resetn;
    logic       enable, sample_valid, sym_start, index_ready, clear_ovf;
    logic [7:0] R_in, G_in, B_in;
    logic [5:0] index_out;
    logic       index_valid, overflow, state_out;

    logic       s1_valid, s1_start;
    logic [7:0] s1_r;
    logic [5:0] s1_index;
    logic       s1_ivalid, s1_ovf, s1_state;

    int         total = 0;
    int         bad   = 0;
    logic [5:0] q0[$];
    logic [5:0] q1[$];

    typedef struct {
        logic [7:0] r0, r1, r2, r3, g, b;
        logic [5:0] exp;
    } vec_t;

    typedef struct {
        logic [7:0] r;
        logic [5:0] exp;
    } sweep_t;

    vec_t   vecs[6];
    sweep_t sweep[6];

    always #5 clk = ~clk;

    rgb_to_index u_dut (
        .clk          (clk),
        .resetn       (resetn),
        .enable       (enable),
        .sample_valid (sample_valid),
        .sym_start    (sym_start),
        .R_in         (R_in),
        .G_in         (G_in),
        .B_in         (B_in),
        .index_out    (index_out),
        .index_valid  (index_valid),
        .index_ready  (index_ready),
        .overflow     (overflow),
        .clear_ovf    (clear_ovf),
        .state_out    (state_out)
    );

    rgb_to_index #(.LOG2_SPS(0)) u_dut1 (
        .clk          (clk),
        .resetn       (resetn),
        .enable       (1'b1),
        .sample_valid (s1_valid),
        .sym_start    (s1_start),
        .R_in         (s1_r),
        .G_in         (8'd0),
        .B_in         (8'd0),
        .index_out    (s1_index),
        .index_valid  (s1_ivalid),
        .index_ready  (1'b1),
        .overflow     (s1_ovf),
        .clear_ovf    (1'b0),
        .state_out    (s1_state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (resetn === 1'b1 && index_valid === 1'b1 && index_ready === 1'b1) begin
            if (q0.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out0: got 0x%0h expected none", index_out);
            end else begin
                check("out0", index_out, q0.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (resetn === 1'b1 && s1_ivalid === 1'b1) begin
            if (q1.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out1: got 0x%0h expected none", s1_index);
            end else begin
                check("out1", s1_index, q1.pop_front());
            end
        end
    end

    task automatic drive(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                         input logic st);
        @(posedge clk);
        #1;
        sample_valid = 1'b1;
        sym_start    = st;
        R_in         = r;
        G_in         = g;
        B_in         = b;
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            sample_valid = 1'b0;
            sym_start    = 1'b0;
        end
    endtask

    task automatic send_sym(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        drive(r, g, b, 1'b1);
        repeat (3) drive(r, g, b, 1'b0);
    endtask

    initial begin
        vecs[0] = '{8'd85, 8'd85, 8'd85, 8'd85, 8'd160, 8'd255, 6'h39};
        vecs[1] = '{8'd40, 8'd44, 8'd44, 8'd45, 8'd0,   8'd0,   6'h01};
        vecs[2] = '{8'd40, 8'd44, 8'd44, 8'd41, 8'd0,   8'd0,   6'h00};
        vecs[3] = '{8'd0,  8'd0,  8'd0,  8'd0,  8'd122, 8'd123, 6'h24};
        vecs[4] = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd208, 8'd207, 6'h2F};
        vecs[5] = '{8'd42, 8'd42, 8'd42, 8'd42, 8'd43,  8'd85,  6'h14};

        sweep[0] = '{8'd42,  6'h0};
        sweep[1] = '{8'd43,  6'h1};
        sweep[2] = '{8'd122, 6'h1};
        sweep[3] = '{8'd123, 6'h2};
        sweep[4] = '{8'd207, 6'h2};
        sweep[5] = '{8'd208, 6'h3};

        resetn       = 1'b0;
        enable       = 1'b1;
        sample_valid = 1'b0;
        sym_start    = 1'b0;
        R_in         = '0;
        G_in         = '0;
        B_in         = '0;
        index_ready  = 1'b1;
        clear_ovf    = 1'b0;
        s1_valid     = 1'b0;
        s1_start     = 1'b0;
        s1_r         = '0;
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;

        check("rst_index_out", index_out, 6'h00);
        check("rst_index_valid", index_valid, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_state", state_out, 1'b0);

        // Latency: valid only after the second edge following the last sample
        q0.push_back(6'h39);
        send_sym(8'd85, 8'd160, 8'd255);
        gap(1);
        check("lat_edge_k_valid", index_valid, 1'b0);
        check("lat_state_accum", state_out, 1'b1);
        @(posedge clk);
        #1;
        check("lat_edge_k1_valid", index_valid, 1'b1);
        check("lat_edge_k1_index", index_out, 6'h39);
        @(posedge clk);
        #1;
        check("lat_one_cycle_valid", index_valid, 1'b0);

        for (int i = 0; i < 6; i++) begin
            q0.push_back(vecs[i].exp);
            drive(vecs[i].r0, vecs[i].g, vecs[i].b, 1'b1);
            drive(vecs[i].r1, vecs[i].g, vecs[i].b, 1'b0);
            drive(vecs[i].r2, vecs[i].g, vecs[i].b, 1'b0);
            drive(vecs[i].r3, vecs[i].g, vecs[i].b, 1'b0);
        end
        gap(4);
        check("table_no_overflow", overflow, 1'b0);
        check("table_drained", q0.size(), 0);

        for (int i = 0; i < 6; i++) begin
            q1.push_back(sweep[i].exp);
            @(posedge clk);
            #1;
            s1_valid = 1'b1;
            s1_start = 1'b1;
            s1_r     = sweep[i].r;
        end
        @(posedge clk);
        #1;
        s1_valid = 1'b0;
        s1_start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("sweep_no_overflow", s1_ovf, 1'b0);
        check("sweep_drained", q1.size(), 0);

        // Backpressure: second symbol must be dropped, first held
        index_ready = 1'b0;
        q0.push_back(6'h00);
        send_sym(8'd0, 8'd0, 8'd0);
        send_sym(8'd255, 8'd255, 8'd255);
        gap(3);
        check("bp_valid_held", index_valid, 1'b1);
        check("bp_index_held", index_out, 6'h00);
        check("bp_overflow", overflow, 1'b1);
        @(posedge clk);
        #1;
        clear_ovf = 1'b1;
        @(posedge clk);
        #1;
        clear_ovf = 1'b0;
        check("bp_ovf_cleared", overflow, 1'b0);
        check("bp_index_still", index_out, 6'h00);
        index_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_accepted_once", index_valid, 1'b0);
        check("bp_drained", q0.size(), 0);

        // Resync discards the partial symbol
        q0.push_back(6'h03);
        drive(8'd0, 8'd0, 8'd0, 1'b1);
        drive(8'd0, 8'd0, 8'd0, 1'b0);
        send_sym(8'd255, 8'd0, 8'd0);
        gap(4);
        check("resync_drained", q0.size(), 0);

        // enable low mid-symbol aborts without output
        drive(8'd50, 8'd50, 8'd50, 1'b1);
        drive(8'd50, 8'd50, 8'd50, 1'b0);
        gap(1);
        enable = 1'b0;
        @(posedge clk);
        #1;
        check("en_low_idle", state_out, 1'b0);
        enable = 1'b1;
        repeat (4) drive(8'd50, 8'd50, 8'd50, 1'b0);
        gap(4);
        check("en_no_start_idle", state_out, 1'b0);
        check("en_no_output", index_valid, 1'b0);

        // Asynchronous reset while holding a pending index with overflow set
        index_ready = 1'b0;
        send_sym(8'd85, 8'd160, 8'd255);
        send_sym(8'd255, 8'd255, 8'd255);
        gap(3);
        check("pre_rst_valid", index_valid, 1'b1);
        check("pre_rst_overflow", overflow, 1'b1);
        #2;
        resetn = 1'b0;
        #1;
        check("async_rst_valid", index_valid, 1'b0);
        check("async_rst_index", index_out, 6'h00);
        check("async_rst_overflow", overflow, 1'b0);
        check("async_rst_state", state_out, 1'b0);
        @(posedge clk);
        #1;
        resetn      = 1'b1;
        index_ready = 1'b1;
        repeat (4) drive(8'd255, 8'd255, 8'd255, 1'b0);
        gap(4);
        check("post_rst_no_output", index_valid, 1'b0);
        check("post_rst_idle", state_out, 1'b0);

        check("final_q0_empty", q0.size(), 0);
        check("final_q1_empty", q1.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rgb_to_index.md
Name: rgb_to_index

Overview:
- Receive-side color-shift-keying demodulator for the RGB link. It performs the inverse of the transmit mapping, where 6-bit index = {B level, G level, R level} and each 2-bit level maps to 0/85/160/255.
- Integrates SPS received R/G/B samples per symbol, averages them, and slices each channel to its nearest 2-bit level.
- Emits the recovered index on a valid/ready interface toward the packet deframer.

Parameters:
- LOG2_SPS, 2: log2 of samples per symbol, range 0..4, so SPS = 1<<LOG2_SPS.
- T01, 43: average >= T01 gives level 1 or higher (midpoint of 0 and 85, rounded up).
- T12, 123: average >= T12 gives level 2 or higher (midpoint of 85 and 160).
- T23, 208: average >= T23 gives level 3 (midpoint of 160 and 255).

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- enable  in  1  demodulator enable; low forces IDLE
- sample_valid  in  1  R_in/G_in/B_in valid this cycle (input is always accepted; no backpressure)
- sym_start  in  1  qualified by sample_valid; marks this sample as the first sample of a symbol
- R_in  in  8  received red amplitude
- G_in  in  8  received green amplitude
- B_in  in  8  received blue amplitude
- index_out  out  6  recovered index: [1:0] R level, [3:2] G level, [5:4] B level
- index_valid  out  1  index_out holds an unconsumed symbol
- index_ready  in  1  downstream accepts index_out when index_valid is also high
- overflow  out  1  sticky; set when a decided symbol was dropped
- clear_ovf  in  1  synchronous clear of overflow
- state_out  out  1  0 = IDLE, 1 = ACCUM (debug)

Behaviour:
- Reset values: index_out = 0, index_valid = 0, overflow = 0, state = IDLE, sample counter = 0, accumulators = 0, decision-pipe valid = 0.
- Accumulators: three, each 8+LOG2_SPS bits wide, unsigned, so they cannot overflow.
- IDLE:
  - Ignores samples until enable & sample_valid & sym_start.
  - On that cycle: load accumulators with the current sample, set count = 1, go to ACCUM.
  - If SPS = 1, the symbol completes on that same edge.
- ACCUM, each enable & sample_valid cycle:
  - If sym_start: the partial symbol is discarded without output. Accumulators reload with the current sample and count = 1 (resync).
  - Otherwise: add the sample and increment count.
- Symbol completion:
  - When the sample that makes count reach SPS is accepted (edge k), latch avg = acc >> LOG2_SPS (truncating) into the decision stage and set its valid bit.
  - Accumulators clear and count = 0. State stays ACCUM (free-running symbol timing).
  - The next sample begins the next symbol; an explicit sym_start is not required.
- Slicing, per channel:
  - level = 3 if avg >= T23; 2 if avg >= T12; 1 if avg >= T01; else 0.
- Output register:
  - At edge k+1 the sliced index is written to index_out and index_valid goes high, provided the output register is free.
  - Latency: index_valid is high after edge k+1 (2 edges after the last sample).
  - Free means index_valid = 0, or index_valid & index_ready in that same cycle. Back-to-back hand-offs with no bubble are required.
- Output full:
  - If the output register is not free at edge k+1, the new symbol is dropped and overflow is set.
  - index_out and index_valid are held; the pending index is never overwritten.
- index_valid and index_out:
  - index_valid drops at the handshake edge unless a new symbol loads on that edge.
  - index_out is stable while index_valid & !index_ready.
- clear_ovf: clears overflow. If clear_ovf and a drop occur on the same edge, the set wins.
- enable low:
  - Next edge goes to IDLE; count and accumulators clear.
  - Any in-flight decision-stage result is discarded.
  - The output register and its handshake are unaffected.
- Gaps: sample_valid low in ACCUM holds all state (gaps are allowed inside a symbol).
- resetn: asserting it mid-symbol or mid-handshake immediately forces all reset values asynchronously. Deassertion is synchronized by the top-level reset generator.

Decomposition:
- Package rgb_csk_pkg:
  - Level constants LVL0..LVL3 = 0/85/160/255, shared with the transmit mapper.
  - Threshold defaults T01/T12/T23.
  - State encoding IDLE = 0, ACCUM = 1.
  - Index field positions: R [1:0], G [3:2], B [5:4].
- Sub-module level_slicer (8-bit avg in, 2-bit level out, thresholds as parameters). Combinational; instantiated three times.

Test Plan:
- LOG2_SPS = 2, sym_start with 4 samples of (85,160,255), index_ready = 1 -> index_out = 0x39, index_valid for one cycle, 2 edges after the 4th sample.
- Threshold sweep, SPS = 1, R = 42/43/122/123/207/208, G = B = 0 -> R level 0/1/1/2/2/3, index_out[5:2] = 0.
- Averaging/truncation: R samples 40,44,44,45 (sum 173, avg 43) -> R level 1. R samples 40,44,44,41 (avg 42) -> R level 0.
- Backpressure, index_ready = 0 over two full symbols (first 0x00, second 0x3F) -> index_out holds 0x00, overflow = 1. After clear_ovf, overflow = 0. Raising index_ready accepts 0x00 once.
- Resync: sym_start after 2 samples, then 4 samples of (255,0,0) -> exactly one output, 0x03. enable low mid-symbol -> no output, state_out = 0.
- resetn asserted while index_valid = 1 -> index_valid, index_out, overflow all 0 immediately. Samples without sym_start afterwards produce no output.
